mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, released synchronously to clk.
REQ-003 req_valid  input  1  CPU-side request present.
REQ-004 req_ready  output  1  master can accept a request this cycle.
REQ-005 req_we  input  1  1 = single-word write, 0 = read burst.
REQ-006 req_addr  input  AWIDTH  start word address.
REQ-007 req_len  input  2  read beats minus one (1..4 beats); ignored for writes.
REQ-008 req_wdata  input  DWIDTH  write data.
REQ-009 rsp_valid  output  1  rsp_data holds one read beat this cycle; no backpressure.
REQ-010 rsp_data  output  DWIDTH  read beat data.
REQ-011 rsp_last  output  1  qualifies the final beat of a burst.
REQ-012 addr  output  AWIDTH  RAM address.
REQ-013 rdEn  output  1  RAM read enable.
REQ-014 wrEn  output  1  RAM write enable.
REQ-015 data  inout  DWIDTH  shared tri-state RAM data bus; driven by the master only during a write cycle, otherwise high-Z.

Function
REQ-016 RAM timing: RAM samples addr/rdEn/wrEn/data at a rising edge; read data for an address sampled at edge E is valid on data until edge E+1.
REQ-017 States: IDLE, WRITE, READ, TURN; req_ready = 1 only in IDLE.
REQ-018 IDLE: rdEn = wrEn = 0, data high-Z; on req_valid at an edge, latch addr/len/wdata/we; go to WRITE if req_we = 1, else READ.
REQ-019 WRITE: exactly one cycle; wrEn = 1, addr = latched address, data = latched wdata; next state IDLE.
REQ-020 READ: rdEn = 1, addr = base + k for beat k = 0..len, one beat per cycle; after issuing beat len, go to TURN.
REQ-021 TURN: one cycle; rdEn = wrEn = 0, bus high-Z; captures the last beat; next state IDLE.
REQ-022 Beat k is registered from data at the edge ending the cycle after its issue; rsp_valid = 1 with rsp_data = beat k in the following cycle.
REQ-023 First rsp_valid appears in the third cycle after the acceptance edge; beats are contiguous; rsp_last = 1 only with beat len.
REQ-024 Address arithmetic is modulo 2^AWIDTH: a burst wraps from all-ones to 0.
REQ-025 rsp_valid, rsp_last = 0 in every cycle without a fresh beat; rsp_data holds its last value.
REQ-026 Back-to-back writes proceed at one per two cycles (WRITE, IDLE); a read followed by a write always passes through TURN, so the RAM and the master never drive data in the same cycle.
REQ-027 A request is never dropped; req_valid outside IDLE is ignored until req_ready = 1.

Reset
REQ-028 While reset = 0: state IDLE; req_ready = 1; rdEn = 0; wrEn = 0; addr = 0; data high-Z; rsp_valid = 0; rsp_last = 0; rsp_data = 0.
REQ-029 Reset mid-burst or mid-write aborts immediately: no further beats and no rsp_last; the bus is released in the same instant.

Structure
REQ-030 DWIDTH, AWIDTH and the state enum typedef mem_state_t reside in the shared InstructionStruct package.
REQ-031 Single module with no sub-module; the state register, beat counter, latched request and response register are all local.

Verification
REQ-032 Bench pairs mem_master with the team's ram model on one shared tri data net; after reset release -> req_ready = 1 and all outputs at their REQ-028 values.
REQ-033 Write 0x5A to address 3, then a 1-beat read of address 3 -> wrEn pulses 1 cycle; rsp_data = 0x5A, rsp_valid = rsp_last = 1 in the third cycle after acceptance.
REQ-034 Write 0x11, 0x22, 0x33, 0x44 to addresses 4..7, then a read with req_len = 3 from 4 -> four contiguous beats 0x11..0x44, rsp_last only on 0x44.
REQ-035 Read with req_len = 1 from address all-ones -> addr sequence all-ones then 0; two beats returned.
REQ-036 Read immediately followed by a write request -> TURN cycle observed; the bus is never multiply-driven (no X on data).
REQ-037 Assert reset during beat 1 of a 4-beat read -> outputs reach reset values immediately; no rsp_last; the next request completes normally.

Source files
------------

// File: rtl/InstructionStruct.sv
// Shared widths and state encoding for the memory master and the blocks around it.
package InstructionStruct;

   localparam int DWIDTH = 8;
   localparam int AWIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      TURN  = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_master.sv
// CPU-side request to single-port tri-state RAM master: single-word writes and
// 1..4 beat read bursts, with a turnaround cycle after every read.
module mem_master
   import InstructionStruct::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [1:0]        req_len,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_data,
   output logic              rsp_last,
   output logic [AWIDTH-1:0] addr,
   output logic              rdEn,
   output logic              wrEn,
   inout  wire  [DWIDTH-1:0] data
);

   mem_state_t        state_q, state_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        len_q, len_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;

   logic              cap_q;
   logic              cap_last_q;
   logic              rsp_valid_q;
   logic              rsp_last_q;
   logic [DWIDTH-1:0] rsp_data_q;

   // State, address, beat counter and latched request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= 2'd0;
         len_q   <= 2'd0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state and RAM strobe decode.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      wdata_d   = wdata_q;
      req_ready = 1'b0;
      rdEn      = 1'b0;
      wrEn      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               len_d   = req_len;
               wdata_d = req_wdata;
               cnt_d   = 2'd0;
               state_d = req_we ? WRITE : READ;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            wrEn    = 1'b1;
            state_d = IDLE;
         end
         READ: begin
            rdEn   = 1'b1;
            // Natural overflow gives the modulo-2^AWIDTH burst wrap.
            addr_d = addr_q + AWIDTH'(1);
            if (cnt_q == len_q) begin
               state_d = TURN;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read data arrives one cycle after issue; register it and flag the final beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_q       <= 1'b0;
         cap_last_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         cap_q       <= (state_q == READ);
         cap_last_q  <= (state_q == READ) && (cnt_q == len_q);
         rsp_valid_q <= cap_q;
         rsp_last_q  <= cap_q & cap_last_q;
         if (cap_q) begin
            rsp_data_q <= data;
         end else begin
            rsp_data_q <= rsp_data_q;
         end
      end
   end

   assign data      = (state_q == WRITE) ? wdata_q : {DWIDTH{1'bz}};
   assign addr      = addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_master.sv
// Randomized bench for mem_master against a RAM on a shared tri-state bus,
// checked by a transaction-level model (shadow memory plus expectation queues).
module tb_mem_master;
   import InstructionStruct::*;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [AWIDTH-1:0] req_addr;
   logic [1:0]        req_len;
   logic [DWIDTH-1:0] req_wdata;
   logic              rsp_valid;
   logic [DWIDTH-1:0] rsp_data;
   logic              rsp_last;
   logic [AWIDTH-1:0] addr;
   logic              rdEn;
   logic              wrEn;
   tri   [DWIDTH-1:0] data;

   mem_master dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .addr      (addr),
      .rdEn      (rdEn),
      .wrEn      (wrEn),
      .data      (data)
   );

   // RAM: samples strobes at an edge, drives read data for the following cycle.
   logic [DWIDTH-1:0] ram [0:(1<<AWIDTH)-1];
   logic              ram_drv = 1'b0;
   logic [DWIDTH-1:0] ram_q   = '0;
   assign data = ram_drv ? ram_q : {DWIDTH{1'bz}};
   always @(posedge clk) begin
      if (wrEn) ram[addr] <= data;
      ram_drv <= rdEn;
      ram_q   <= ram[addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference model state.
   typedef struct { int c; logic we; logic [AWIDTH-1:0] a; logic [DWIDTH-1:0] d; } iss_t;
   typedef struct { int c; logic [DWIDTH-1:0] d; logic last; } rsp_t;
   logic [DWIDTH-1:0] mem_ref [0:(1<<AWIDTH)-1];
   iss_t iss_q[$];
   rsp_t rsp_q[$];
   logic mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         iss_t e;
         rsp_t r;
         chk("bus_conflict", {31'd0, wrEn & ram_drv}, 32'd0);
         if (rdEn || wrEn) begin
            if (iss_q.size() == 0) begin
               chk("unexpected_issue", 32'd1, 32'd0);
            end else begin
               e = iss_q.pop_front();
               chk("issue_cycle", cyc, e.c);
               chk("issue_wr", {31'd0, wrEn}, {31'd0, e.we});
               chk("issue_rd", {31'd0, rdEn}, {31'd0, ~e.we});
               chk("issue_addr", {24'd0, addr}, {24'd0, e.a});
               if (e.we) chk("write_data", {24'd0, data}, {24'd0, e.d});
            end
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_cycle", cyc, r.c);
               chk("rsp_data", {24'd0, rsp_data}, {24'd0, r.d});
               chk("rsp_last", {31'd0, rsp_last}, {31'd0, r.last});
            end
         end else begin
            chk("idle_last", {31'd0, rsp_last}, 32'd0);
         end
      end
   end

   // Present a request at a negedge, hold until accepted, then record expectations.
   task automatic do_req(input logic we, input logic [AWIDTH-1:0] a, input logic [1:0] len,
                         input logic [DWIDTH-1:0] d, output int acc);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      acc = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_len = len; req_wdata = d;
      for (int t = 0; t < 20; t++) begin
         rdy = req_ready;
         acc = cyc + 1;
         @(posedge clk);
         if (rdy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         chk("accept_timeout", 32'd1, 32'd0);
      end else if (we) begin
         mem_ref[a] = d;
         iss_q.push_back('{c: acc, we: 1'b1, a: a, d: d});
      end else begin
         for (int k = 0; k <= int'(len); k++) begin
            logic [AWIDTH-1:0] ak;
            ak = a + AWIDTH'(k);
            iss_q.push_back('{c: acc + k, we: 1'b0, a: ak, d: '0});
            rsp_q.push_back('{c: acc + 2 + k, d: mem_ref[ak], last: (k == int'(len))});
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int t = 0; t < 40; t++) begin
         if (iss_q.size() == 0 && rsp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_issue", iss_q.size(), 32'd0);
      chk("drain_rsp", rsp_q.size(), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_rdEn"},  {31'd0, rdEn}, 32'd0);
      chk({tag, "_wrEn"},  {31'd0, wrEn}, 32'd0);
      chk({tag, "_addr"},  {24'd0, addr}, 32'd0);
      chk({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rspl"},  {31'd0, rsp_last}, 32'd0);
      chk({tag, "_rspd"},  {24'd0, rsp_data}, 32'd0);
   endtask

   initial begin
      int a1, a2;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_len = 2'd0; req_wdata = '0;
      for (int i = 0; i < (1 << AWIDTH); i++) begin
         ram[i]     = DWIDTH'($urandom);
         mem_ref[i] = ram[i];
      end
      repeat (3) @(negedge clk);
      chk_reset_vals("in_reset");
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("after_reset");
      mon_en = 1'b1;

      // Write then single-beat read of the same word.
      do_req(1'b1, 8'h03, 2'd0, 8'h5A, a1);
      do_req(1'b0, 8'h03, 2'd0, 8'h00, a2);
      idle(1);
      drain();
      chk("rd_after_wr_data", {24'd0, ram[3]}, 32'h5A);

      // Back-to-back writes then a 4-beat burst.
      do_req(1'b1, 8'h04, 2'd0, 8'h11, a1);
      do_req(1'b1, 8'h05, 2'd0, 8'h22, a2);
      chk("b2b_write_gap", a2 - a1, 32'd2);
      do_req(1'b1, 8'h06, 2'd0, 8'h33, a1);
      do_req(1'b1, 8'h07, 2'd0, 8'h44, a1);
      do_req(1'b0, 8'h04, 2'd3, 8'h00, a1);
      idle(1);
      drain();

      // Burst wrapping past the top of the address space.
      do_req(1'b0, 8'hFF, 2'd1, 8'h00, a1);
      idle(1);
      drain();

      // Read immediately followed by a write must pass through TURN.
      do_req(1'b0, 8'h10, 2'd2, 8'h00, a1);
      do_req(1'b1, 8'h10, 2'd0, 8'hC3, a2);
      chk("turn_gap", a2 - a1, 32'd5);
      do_req(1'b0, 8'h10, 2'd0, 8'h00, a1);
      idle(1);
      drain();

      // Reset asserted during beat 1 of a 4-beat read.
      do_req(1'b0, 8'h20, 2'd3, 8'h00, a1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      req_valid = 1'b0;
      #1;
      chk_reset_vals("mid_burst");
      iss_q.delete();
      rsp_q.delete();
      repeat (3) @(negedge clk);
      chk_reset_vals("held_reset");
      reset = 1'b1;
      do_req(1'b0, 8'h04, 2'd3, 8'h00, a1);
      idle(1);
      drain();

      // Randomized mix of writes and bursts with random gaps.
      for (int i = 0; i < 80; i++) begin
         do_req(1'($urandom), AWIDTH'($urandom), 2'($urandom), DWIDTH'($urandom), a1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
      end
      idle(1);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout obs=%0d exp=0", cyc);
      $fatal(1, "timeout");
   end

endmodule
